// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues the PC-stage request to the instruction SRAM with
// kseg0/kseg1 translation, and keeps the IF/ID register plus a one-word hold buffer.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [64:0] pc_to_ic_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [96:0] if_to_id_bus
);
    localparam logic STOP = 1'b1;

    logic [31:0] pc_exc;
    logic        pc_ce;
    logic [31:0] pc_va;
    logic        adel;
    logic        stall_if;
    logic        stall_id;
    logic        unused_stall;

    logic [31:0] id_exc_q, id_exc_d;
    logic        id_ce_q, id_ce_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_fetched_q, id_fetched_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] id_inst;

    assign pc_exc       = pc_to_ic_bus[64:33];
    assign pc_ce        = pc_to_ic_bus[32];
    assign pc_va        = pc_to_ic_bus[31:0];
    assign adel         = pc_exc[16];
    assign stall_if     = stall[1];
    assign stall_id     = stall[2];
    assign unused_stall = ^{stall[5:3], stall[0]};

    assign inst_sram_en    = pc_ce & ~adel & (stall_if != STOP) & ~flush;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    // kseg0 and kseg1 both alias the low 512 MB of physical memory.
    always_comb begin
        inst_sram_addr = pc_va;
        if (pc_va[31:29] == 3'b100 || pc_va[31:29] == 3'b101) begin
            inst_sram_addr = {3'b000, pc_va[28:0]};
        end
    end

    always_comb begin
        id_exc_d     = id_exc_q;
        id_ce_d      = id_ce_q;
        id_pc_d      = id_pc_q;
        id_fetched_d = id_fetched_q;
        if (flush || (stall_if == STOP && stall_id != STOP)) begin
            id_exc_d     = 32'h0;
            id_ce_d      = 1'b0;
            id_pc_d      = 32'h0;
            id_fetched_d = 1'b0;
        end else if (stall_if != STOP) begin
            id_exc_d     = pc_exc;
            id_ce_d      = pc_ce;
            id_pc_d      = pc_va;
            id_fetched_d = inst_sram_en;
        end
    end

    // rdata is only valid for one cycle, so the first stalled edge must capture it.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        if (flush || stall_id != STOP) begin
            buf_valid_d = 1'b0;
        end else if (id_fetched_q && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_exc_q     <= 32'h0;
            id_ce_q      <= 1'b0;
            id_pc_q      <= 32'h0;
            id_fetched_q <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_inst_q   <= 32'h0;
        end else begin
            id_exc_q     <= id_exc_d;
            id_ce_q      <= id_ce_d;
            id_pc_q      <= id_pc_d;
            id_fetched_q <= id_fetched_d;
            buf_valid_q  <= buf_valid_d;
            buf_inst_q   <= buf_inst_d;
        end
    end

    always_comb begin
        if (buf_valid_q) begin
            id_inst = buf_inst_q;
        end else if (id_fetched_q) begin
            id_inst = inst_sram_rdata;
        end else begin
            id_inst = 32'h0;
        end
    end

    assign if_to_id_bus = {id_exc_q, id_ce_q, id_pc_q, id_inst};

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: synchronous SRAM model that scrambles rdata
// outside the valid cycle, plus a pc/memory-level reference model of the ID-stage view.
module tb_inst_fetch;
    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [64:0] pc_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [96:0] if_to_id_bus;

    int n_checks = 0;
    int n_fail   = 0;
    logic [96:0] exp_q[$];

    // reference model state: what ID holds, expressed as pc + "was it fetched"
    logic [31:0] m_exc = 32'h0;
    logic        m_ce = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_fetched = 1'b0;
    logic        m_bv = 1'b0;
    logic [31:0] m_bw = 32'h0;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .pc_to_ic_bus    (pc_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .if_to_id_bus    (if_to_id_bus)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pa);
        return (pa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // SRAM: data valid only the cycle after an enabled edge, garbage otherwise
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    function automatic logic [96:0] exp_bus();
        logic [31:0] inst;
        inst = m_bv ? m_bw : (m_fetched ? mem_word(phys(m_pc)) : 32'h0);
        return {m_exc, m_ce, m_pc, inst};
    endfunction

    function automatic logic exp_en();
        return pc_bus[32] & ~pc_bus[49] & ~stall[1] & ~flush;
    endfunction

    task automatic model_edge();
        logic en;
        en = exp_en();
        if (rst) begin
            m_exc = 0; m_ce = 0; m_pc = 0; m_fetched = 0; m_bv = 0; m_bw = 0;
        end else begin
            if (flush || !stall[2]) m_bv = 1'b0;
            else if (m_fetched && !m_bv) begin
                m_bv = 1'b1;
                m_bw = mem_word(phys(m_pc));
            end
            if (flush || (stall[1] && !stall[2])) begin
                m_exc = 0; m_ce = 0; m_pc = 0; m_fetched = 0;
            end else if (!stall[1]) begin
                m_exc = pc_bus[64:33]; m_ce = pc_bus[32]; m_pc = pc_bus[31:0]; m_fetched = en;
            end
        end
        exp_q.push_back(exp_bus());
    endtask

    // driver tasks
    task automatic set_pc(input logic [31:0] exc, input logic ce, input logic [31:0] pc);
        pc_bus = {exc, ce, pc};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [96:0] e;
        rst = 1; flush = 0; stall = 6'b0; set_pc(32'h0, 1'b0, 32'hBFC0_0000);
        #3;
        n_checks++;
        if (inst_sram_en !== 1'b0) begin
            $display("FAIL reset_en: got %b exp 0", inst_sram_en); n_fail++;
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e || if_to_id_bus !== 97'h0) begin
            $display("FAIL reset_bus: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
        n_checks++;
        if (dut.buf_valid_q !== 1'b0) begin
            $display("FAIL reset_buf_valid: got %b exp 0", dut.buf_valid_q); n_fail++;
        end
        rst = 0;
    endtask

    task automatic test_sequential();
        logic [96:0] e;
        for (int i = 0; i < 6; i++) begin
            set_pc(32'h0, 1'b1, 32'hBFC0_0000 + 32'(i * 4));
            #3;
            n_checks++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1FC0_0000 + 32'(i * 4)) begin
                $display("FAIL seq_addr[%0d]: got en=%b addr=%h exp en=1 addr=%h",
                         i, inst_sram_en, inst_sram_addr, 32'h1FC0_0000 + 32'(i * 4));
                n_fail++;
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== e || if_to_id_bus[64] !== 1'b1
                || if_to_id_bus[63:32] !== 32'hBFC0_0000 + 32'(i * 4)) begin
                $display("FAIL seq_bus[%0d]: got %h exp %h", i, if_to_id_bus, e); n_fail++;
            end
        end
    endtask

    task automatic test_id_stall();
        logic [96:0] e;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h0, 1'b1, 32'hBFC0_0000 + 32'(i * 4));
            tick();
            void'(exp_q.pop_front());
        end
        set_pc(32'h0, 1'b1, 32'hBFC0_000C);
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (inst_sram_en !== 1'b0) begin
                $display("FAIL stall_en[%0d]: got %b exp 0", i, inst_sram_en); n_fail++;
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== e || if_to_id_bus[31:0] !== mem_word(32'h1FC0_0008)) begin
                $display("FAIL stall_hold[%0d]: got %h exp %h", i, if_to_id_bus, e); n_fail++;
            end
        end
        stall = 6'b0;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e || if_to_id_bus[63:32] !== 32'hBFC0_000C) begin
            $display("FAIL stall_release: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
    endtask

    task automatic test_if_bubble();
        logic [96:0] e;
        set_pc(32'h0, 1'b1, 32'hBFC0_0010);
        stall = 6'b000011;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e || if_to_id_bus[64] !== 1'b0 || if_to_id_bus[31:0] !== 32'h0) begin
            $display("FAIL if_bubble: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
        stall = 6'b0;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e) begin
            $display("FAIL if_bubble_resume: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
    endtask

    task automatic test_flush();
        logic [96:0] e;
        set_pc(32'h0, 1'b1, 32'hBFC0_0014);
        tick();
        void'(exp_q.pop_front());
        set_pc(32'h0, 1'b1, 32'hBFC0_0018);
        stall = 6'b000111;
        tick(); void'(exp_q.pop_front());
        tick(); void'(exp_q.pop_front());
        stall = 6'b0;
        flush = 1;
        #3;
        n_checks++;
        if (inst_sram_en !== 1'b0) begin
            $display("FAIL flush_en: got %b exp 0", inst_sram_en); n_fail++;
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e || if_to_id_bus !== 97'h0 || dut.buf_valid_q !== 1'b0) begin
            $display("FAIL flush_bus: got %h buf=%b exp %h buf=0", if_to_id_bus, dut.buf_valid_q, e);
            n_fail++;
        end
        flush = 0;
        set_pc(32'h0, 1'b1, 32'hBFC0_0380);
        #3;
        n_checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1FC0_0380) begin
            $display("FAIL flush_next_addr: got en=%b addr=%h exp en=1 addr=1fc00380",
                     inst_sram_en, inst_sram_addr);
            n_fail++;
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e) begin
            $display("FAIL flush_next_bus: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
    endtask

    task automatic test_adel();
        logic [96:0] e;
        set_pc(32'h0001_0000, 1'b1, 32'hBFC0_0002);
        #3;
        n_checks++;
        if (inst_sram_en !== 1'b0) begin
            $display("FAIL adel_en: got %b exp 0", inst_sram_en); n_fail++;
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e || if_to_id_bus !== {32'h0001_0000, 1'b1, 32'hBFC0_0002, 32'h0}) begin
            $display("FAIL adel_bus: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
    endtask

    task automatic test_kuseg();
        logic [96:0] e;
        set_pc(32'h0, 1'b1, 32'h0040_0000);
        #3;
        n_checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h0040_0000) begin
            $display("FAIL kuseg_addr: got en=%b addr=%h exp en=1 addr=00400000",
                     inst_sram_en, inst_sram_addr);
            n_fail++;
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e) begin
            $display("FAIL kuseg_bus: got %h exp %h", if_to_id_bus, e); n_fail++;
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [96:0] e;
        set_pc(32'h0, 1'b1, 32'hBFC0_0020);
        tick(); void'(exp_q.pop_front());
        set_pc(32'h0, 1'b1, 32'hBFC0_0024);
        stall = 6'b000111;
        tick(); void'(exp_q.pop_front());
        tick(); void'(exp_q.pop_front());
        rst = 1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== e || if_to_id_bus !== 97'h0 || dut.buf_valid_q !== 1'b0) begin
            $display("FAIL reset_mid_stall: got %h buf=%b exp %h buf=0",
                     if_to_id_bus, dut.buf_valid_q, e);
            n_fail++;
        end
        rst = 0;
        stall = 6'b0;
    endtask

    task automatic test_random();
        logic [96:0] e;
        logic [31:0] pc;
        logic [31:0] exc;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       pc = 32'hBFC0_0000 + ($urandom_range(0, 255) << 2);
                1:       pc = 32'h8000_1000 + ($urandom_range(0, 255) << 2);
                2:       pc = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
                default: pc = $urandom;
            endcase
            exc = ($urandom_range(0, 7) == 0) ? 32'h0001_0000 : 32'h0;
            set_pc(exc, ($urandom_range(0, 5) != 0), pc);
            case ($urandom_range(0, 4))
                0, 1:    stall = 6'b000000;
                2:       stall = 6'b000011;
                default: stall = 6'b000111;
            endcase
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            #3;
            n_checks++;
            if (inst_sram_en !== exp_en() || (exp_en() && inst_sram_addr !== phys(pc))) begin
                $display("FAIL rand_fetch[%0d]: got en=%b addr=%h exp en=%b addr=%h",
                         i, inst_sram_en, inst_sram_addr, exp_en(), phys(pc));
                n_fail++;
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== e) begin
                $display("FAIL rand_bus[%0d]: got %h exp %h", i, if_to_id_bus, e); n_fail++;
            end
        end
        rst = 0; flush = 0; stall = 6'b0;
    endtask

    initial begin
        rst = 1; flush = 0; stall = 6'b0; pc_bus = 65'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_id_stall();
        test_if_bubble();
        test_flush();
        test_adel();
        test_kuseg();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the PC stage. Takes the PC-stage bus {excepttype, ce, pc} and issues the fetch to the synchronous instruction SRAM, with kseg0/kseg1 address translation. Holds the IF/ID pipeline register and a one-entry instruction hold buffer, so a fetched word is never lost while decode is stalled. Produces the bus consumed by the ID stage.

## Interface
- No parameters. Widths come from `lib/defines.vh`: `StallBus` is 6 bits, `PC_TO_IT_WD` is 65, `IF_TO_ID_WD` is 97.
- clk  in  1  Clock.
- rst  in  1  Reset. One clock; reset is synchronous and active-high.
- stall  in  6  Pipeline stall vector. Bit 1 stalls IF; bit 2 stalls ID. The vector is monotone: stall[2] implies stall[1].
- flush  in  1  Exception/eret flush. Kills all in-flight fetch state.
- pc_to_ic_bus  in  65  Bus from the PC stage:
  - bits 64:33: excepttype (bit 16 of the field = fetch AdEL)
  - bit 32: ce
  - bits 31:0: pc
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_wen  out  4  Constant 4'b0.
- inst_sram_addr  out  32  Physical fetch address.
- inst_sram_wdata  out  32  Constant 0.
- inst_sram_rdata  in  32  SRAM read data. Valid only in the cycle after the enable edge.
- if_to_id_bus  out  97  Bus to the ID stage:
  - bits 96:65: excepttype
  - bit 64: valid
  - bits 63:32: pc
  - bits 31:0: inst

## Operation
- Fetch address, per PC-stage field:
  - adel = excepttype[16].
  - inst_sram_en = ce & ~adel & (stall[1]==NoStop) & ~flush. This is combinational.
- Address translation is combinational:
  - pc[31:29] of 3'b100 or 3'b101 (kseg0/kseg1): addr = {3'b000, pc[28:0]}.
  - Otherwise: addr = pc.
- IF/ID register (id_exc, id_ce, id_pc, id_fetched) updates at posedge, first match wins:
  1. rst or flush: bubble. All fields 0.
  2. stall[1]==Stop and stall[2]==NoStop: bubble.
  3. stall[1]==NoStop: load excepttype, ce and pc; id_fetched <= inst_sram_en.
  4. Otherwise: hold.
- Hold buffer (buf_valid, buf_inst):
  - rst or flush: buf_valid <= 0.
  - stall[2]==NoStop: buf_valid <= 0. ID consumes the word this edge.
  - id_fetched & ~buf_valid & stall[2]==Stop: buf_inst <= inst_sram_rdata; buf_valid <= 1.
  - Otherwise: hold.
- inst output mux, in priority order:
  - buf_valid: buf_inst.
  - id_fetched: inst_sram_rdata.
  - Otherwise: 32'h0 (NOP). This covers AdEL, ce=0 and bubbles; excepttype still propagates for AdEL.
- valid = id_ce.

## Timing
- Reset values:
  - IF/ID fields all 0, so if_to_id_bus = 0.
  - buf_valid = 0, buf_inst = 0.
  - inst_sram_en follows the PC bus. The PC stage drives ce=0 during reset, so en = 0.
- Latency: a request issued at edge N (en high in cycle N-1) appears on if_to_id_bus in cycle N with inst taken live from rdata. Throughput is 1 word/cycle.
- Stall entry: on the first edge with stall[2] set, rdata is captured. From the next cycle the buffer drives inst for as long as the stall lasts, even if the SRAM output changes.
- Stall release: the edge with stall[2]==NoStop clears the buffer and, if stall[1]==NoStop, loads the next PC.
- Flush has priority over stall, buffer capture and issue:
  - inst_sram_en is forced low in the flush cycle.
  - The next cycle shows a bubble and no stale rdata. id_fetched = 0.
- Flush arriving while the buffer is full: the buffer is cleared at that edge.
- AdEL pc: no SRAM access. The stage still carries pc and excepttype with valid=1 and inst=0.
- Reset mid-stall: everything clears in one edge; no buffered word survives.

## Test plan
- Sequential fetch:
  - Stimulus: PC bus ce=1, pc 0xBFC00000, 0xBFC00004, ... with no stalls.
  - Required: inst_sram_addr = 0x1FC00000, 0x1FC00004, ...
  - Required: each word appears on if_to_id_bus one cycle later with valid=1 and matching pc.
- ID stall:
  - Stimulus: stall=6'b000111 for 3 cycles after the word at 0x1FC00008 returns; the SRAM model scrambles rdata meanwhile.
  - Required: inst stays at the captured word for all 3 cycles.
  - Required: en=0 during the stall; the next pc follows in order after release.
- IF-only bubble:
  - Stimulus: stall=6'b000011.
  - Required: next cycle valid=0 and inst=0; buffer unchanged.
- Flush:
  - Stimulus: flush for 1 cycle while the buffer is full and a request is in flight.
  - Required: en=0 that cycle; next cycle if_to_id_bus = 0; the next pc (0xBFC00380) is fetched normally.
- AdEL:
  - Stimulus: pc = 0xBFC00002, excepttype = 0x00010000.
  - Required: en=0; next cycle valid=1, pc=0xBFC00002, excepttype=0x00010000, inst=0.
- Mapping and reset:
  - Stimulus: pc = 0x00400000 (kuseg).
  - Required: addr = 0x00400000, untranslated.
  - Stimulus: rst asserted during a buffered stall.
  - Required: bus = 0 and buf_valid = 0 after one edge.
